simon_playback_engine: RTL and testbench

SIMON_PLAYBACK_ENGINE -- requirements
Module: simon_playback_engine

---
 rtl/simon_playback_engine.sv | 127 ++++++++++++
 tb/tb_simon_playback_engine.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/simon_playback_engine.sv
// Simon-style pattern playback: reads entries 0..end from an external 64x4
// pattern memory and shows each on the LEDs for ON_CYCLES, then blanks for OFF_CYCLES.
module simon_playback_engine #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] last_addr,
   output logic [5:0] r_addr,
   input  logic [3:0] r_data,
   output logic [3:0] pattern_leds,
   output logic       busy,
   output logic       done
);

   localparam logic [15:0] ON_LOAD  = 16'(ON_CYCLES - 1);
   localparam logic [15:0] OFF_LOAD = 16'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHOW,
      S_GAP,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [5:0]  r_addr_q, r_addr_d;
   logic [5:0]  end_q, end_d;
   logic [3:0]  leds_q, leds_d;

   // NOTE: every register holds its value unless a branch overrides it; the
   // defaults at the top of always_comb are what keep this block latch-free.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      r_addr_d = r_addr_q;
      end_d    = end_q;
      leds_d   = leds_q;

      unique case (state_q)
         S_IDLE: begin
            leds_d = 4'd0;
            if (start && !abort) begin
               end_d    = last_addr;
               r_addr_d = 6'd0;
               state_d  = S_FETCH;
            end
         end

         S_FETCH: begin
            if (abort) begin
               leds_d  = 4'd0;
               state_d = S_IDLE;
            end else begin
               leds_d  = r_data;
               timer_d = ON_LOAD;
               state_d = S_SHOW;
            end
         end

         S_SHOW: begin
            if (abort) begin
               leds_d  = 4'd0;
               state_d = S_IDLE;
            end else if (timer_q == 16'd0) begin
               leds_d  = 4'd0;
               timer_d = OFF_LOAD;
               state_d = S_GAP;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end

         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (timer_q != 16'd0) begin
               timer_d = timer_q - 16'd1;
            end else if (r_addr_q == end_q) begin
               // Last entry shown: finish without stepping the address, so 63 never wraps.
               state_d = S_FIN;
            end else begin
               r_addr_d = r_addr_q + 6'd1;
               state_d  = S_FETCH;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            leds_d  = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         timer_q  <= 16'd0;
         r_addr_q <= 6'd0;
         end_q    <= 6'd0;
         leds_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         r_addr_q <= r_addr_d;
         end_q    <= end_d;
         leds_q   <= leds_d;
      end
   end

   assign r_addr       = r_addr_q;
   assign pattern_leds = leds_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_FIN);

endmodule

// File: tb/tb_simon_playback_engine.sv
// Directed self-checking bench for simon_playback_engine with ON_CYCLES=3, OFF_CYCLES=2.
module tb_simon_playback_engine;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = 1 + ON + OFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [5:0] last_addr;
   logic [5:0] r_addr;
   logic [3:0] r_data;
   logic [3:0] pattern_leds;
   logic       busy;
   logic       done;

   logic [3:0] mem [64];
   int checks = 0;
   int errors = 0;

   assign r_data = mem[r_addr];

   always #5 clk = ~clk;

   simon_playback_engine #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .last_addr(last_addr),
      .r_addr(r_addr), .r_data(r_data), .pattern_leds(pattern_leds),
      .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " leds"}, 32'(pattern_leds), 32'd0);
   endtask

   // Pulses start from a negedge, then follows the whole n-entry playback
   // cycle by cycle. At busy-cycle index inj, start is re-pulsed and last_addr
   // is changed; both must be ignored.
   task automatic play_check(input string tag, input int n, input int inj);
      int e, pos;
      logic [3:0] exp_leds;
      start = 1'b1;
      for (int k = 0; k <= n * PER; k++) begin
         @(negedge clk);
         start = (k == inj) ? 1'b1 : 1'b0;
         if (k == inj) last_addr = 6'd5;
         e   = k / PER;
         pos = k % PER;
         exp_leds = (k < n * PER && pos >= 1 && pos <= ON) ? mem[e] : 4'd0;
         check($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'd1);
         check($sformatf("%s k=%0d done", tag, k), 32'(done), 32'(k == n * PER));
         check($sformatf("%s k=%0d leds", tag, k), 32'(pattern_leds), 32'(exp_leds));
         check($sformatf("%s k=%0d addr", tag, k), 32'(r_addr),
               (k == n * PER) ? 32'(n - 1) : 32'(e));
      end
      start = 1'b0;
      @(negedge clk);
      check_idle({tag, " after"});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; last_addr = 6'd0;
      for (int i = 0; i < 64; i++) mem[i] = 4'(i);
      #1;
      check_idle("reset");
      check("reset addr", 32'(r_addr), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("post-reset");

      // Three entries 1,2,4; 19 busy cycles ending in the done pulse
      mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
      last_addr = 6'd2;
      play_check("seq3", 3, -1);

      // Single entry
      mem[0] = 4'd8;
      last_addr = 6'd0;
      play_check("single", 1, -1);

      // Full 64-entry sweep, 385 busy cycles
      for (int i = 0; i < 64; i++) mem[i] = 4'(i);
      last_addr = 6'd63;
      play_check("full", 64, -1);

      // Re-pulse start and change last_addr during entry 0's GAP
      mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
      last_addr = 6'd2;
      play_check("restart-ignored", 3, 5);

      // Abort during the SHOW of entry 1
      last_addr = 6'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (PER + 1) @(negedge clk);
      check("abort pre leds", 32'(pattern_leds), 32'd2);
      check("abort pre addr", 32'(r_addr), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort");
      check("abort addr kept", 32'(r_addr), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("abort quiet %0d", i), 32'(done | busy), 32'd0);
      end
      play_check("replay", 3, -1);

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      check_idle("start+abort");
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check_idle("start+abort 2");

      // Asynchronous reset mid-SHOW, between clock edges
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst pre leds", 32'(pattern_leds), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_idle("async rst");
      check("async rst addr", 32'(r_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("rst quiet %0d", i), 32'(done | busy), 32'd0);
      end
      play_check("after-rst", 3, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
